mu0_control: RTL

//  MU0 control unit: fetch/execute FSM driving mu0_datapath select/enable/ALU-mode lines from F, N, Z.

---
 rtl/mu0_control.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mu0_control.sv
// mu0_control: MU0 fetch/execute FSM with Mem_ready wait states, bus watchdog,
// halt/illegal/bus-error status and a saturating retired-instruction counter.
module mu0_control #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [3:0]       F,
    input  logic             N,
    input  logic             Z,
    input  logic             Mem_ready,
    output logic             X_sel,
    output logic             Y_sel,
    output logic             Addr_sel,
    output logic             PC_En,
    output logic             IR_En,
    output logic             Acc_En,
    output logic [1:0]       M,
    output logic             Rd,
    output logic             Wr,
    output logic             Halted,
    output logic             Illegal,
    output logic             Bus_err,
    output logic [CNT_W-1:0] Instr_count
);
    typedef enum logic [1:0] {FETCH, EXECUTE, HALT} state_t;

    state_t             state_q, state_d;
    logic [15:0]        wait_q, wait_d;
    logic               illegal_q, illegal_d, bus_err_q, bus_err_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               mem_phase, retire, timeout;

    always_comb begin
        X_sel     = 1'b0;
        Y_sel     = 1'b0;
        Addr_sel  = 1'b0;
        PC_En     = 1'b0;
        IR_En     = 1'b0;
        Acc_En    = 1'b0;
        M         = 2'b00;
        Rd        = 1'b0;
        Wr        = 1'b0;
        Halted    = 1'b0;
        mem_phase = 1'b0;
        retire    = 1'b0;
        state_d   = state_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        case (state_q)
            FETCH: begin
                Rd        = 1'b1;
                X_sel     = 1'b1;
                M         = 2'b10;
                IR_En     = Mem_ready;
                PC_En     = Mem_ready;
                mem_phase = 1'b1;
                state_d   = Mem_ready ? EXECUTE : FETCH;
            end
            EXECUTE: begin
                case (F)
                    4'd0: begin
                        Addr_sel  = 1'b1;
                        Rd        = 1'b1;
                        Acc_En    = Mem_ready;
                        mem_phase = 1'b1;
                    end
                    4'd1: begin
                        Addr_sel  = 1'b1;
                        Wr        = 1'b1;
                        mem_phase = 1'b1;
                    end
                    4'd2, 4'd3: begin
                        Addr_sel  = 1'b1;
                        Rd        = 1'b1;
                        M         = F[0] ? 2'b11 : 2'b01;
                        Acc_En    = Mem_ready;
                        mem_phase = 1'b1;
                    end
                    4'd4, 4'd5, 4'd6: begin
                        Y_sel   = 1'b1;
                        PC_En   = (F == 4'd5) ? ~N : (F == 4'd6) ? ~Z : 1'b1;
                        state_d = FETCH;
                        retire  = 1'b1;
                    end
                    4'd7: begin
                        state_d = HALT;
                        retire  = 1'b1;
                    end
                    default: begin
                        state_d   = HALT;
                        illegal_d = 1'b1;
                    end
                endcase
                if (mem_phase && Mem_ready) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            default: begin
                Halted  = 1'b1;
                state_d = HALT;
            end
        endcase
        // Ready on the final allowed cycle still completes; only a missing ready times out.
        timeout = mem_phase && !Mem_ready && (wait_q == 16'(MAX_WAIT - 1));
        if (timeout) begin
            state_d   = HALT;
            bus_err_d = 1'b1;
        end
        wait_d  = (mem_phase && !Mem_ready) ? wait_q + 16'd1 : 16'd0;
        count_d = (retire && !(&count_q)) ? count_q + CNT_W'(1) : count_q;
        if (Reset) begin
            state_d   = FETCH;
            wait_d    = 16'd0;
            illegal_d = 1'b0;
            bus_err_d = 1'b0;
            count_d   = '0;
            X_sel     = 1'b0;
            Y_sel     = 1'b0;
            Addr_sel  = 1'b0;
            PC_En     = 1'b0;
            IR_En     = 1'b0;
            Acc_En    = 1'b0;
            M         = 2'b00;
            Rd        = 1'b0;
            Wr        = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        state_q   <= state_d;
        wait_q    <= wait_d;
        illegal_q <= illegal_d;
        bus_err_q <= bus_err_d;
        count_q   <= count_d;
    end

    assign Illegal     = illegal_q;
    assign Bus_err     = bus_err_q;
    assign Instr_count = count_q;
endmodule
